// File: rtl/mips_ctrl_pkg.sv
// Shared constants and the control-word type for the multicycle MIPS controller.
// State codes, opcodes and the datapath mux select codes all live here.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUB_RT     = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational output decode: current state, latched opcode, zero flag and
// memory handshake map to the full datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state control word; anything not set stays inactive.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_mips_ctrl.sv
// Multicycle MIPS control FSM: state register, latched opcode, illegal-opcode
// pulse and retired-instruction counter around the combinational decode.
module multicycle_mips_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [5:0]       op_q_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             illegal_r;
    logic             illegal_set_s;
    logic             retire_s;
    ctrl_t            dec_s;
    ctrl_t            ctrl_s;

    mips_ctrl_decode u_decode (
        .state     (state_r),
        .op_q      (op_q_r),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (dec_s)
    );

    // Next state; retire_s marks the transitions that complete an instruction.
    always_comb begin
        next_state_s  = S_FETCH;
        retire_s      = 1'b0;
        illegal_set_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
                    OP_R:           next_state_s = S_EXECUTE;
                    OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
                    OP_J:           next_state_s = S_JUMP;
                    OP_ADDI:        next_state_s = S_ADDI_EXEC;
                    default: begin
                        next_state_s  = S_FETCH;
                        illegal_set_s = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q_r == OP_LW) next_state_s = S_MEM_READ;
                else                 next_state_s = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (mem_ready) next_state_s = S_MEM_WB;
                else           next_state_s = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_EXECUTE:   next_state_s = S_R_WB;
            S_ADDI_EXEC: next_state_s = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // State, latched opcode, illegal pulse and counter; counter holds unless retiring.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_FETCH;
            op_q_r        <= 6'd0;
            instr_count_r <= '0;
            illegal_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_set_s;
            if (state_r == S_DECODE) op_q_r <= opcode;
            if (retire_s) instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Reset forces every control output inactive, even before the first edge.
    always_comb begin
        if (reset) ctrl_s = CTRL_IDLE;
        else       ctrl_s = dec_s;
    end

    assign pc_write    = ctrl_s.pc_write;
    assign iord        = ctrl_s.iord;
    assign mem_read    = ctrl_s.mem_read;
    assign mem_write   = ctrl_s.mem_write;
    assign ir_write    = ctrl_s.ir_write;
    assign reg_dst     = ctrl_s.reg_dst;
    assign mem_to_reg  = ctrl_s.mem_to_reg;
    assign reg_write   = ctrl_s.reg_write;
    assign alu_src_a   = ctrl_s.alu_src_a;
    assign alu_src_b   = ctrl_s.alu_src_b;
    assign alu_op      = ctrl_s.alu_op;
    assign pc_source   = ctrl_s.pc_source;
    assign illegal_op  = illegal_r & ~reset;
    assign instr_count = instr_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_multicycle_mips_ctrl.sv
// Directed bench for multicycle_mips_ctrl: walks each instruction class through
// its state sequence and checks the control outputs against hand-derived values.
module tb_multicycle_mips_ctrl;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [3:0]  state;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt;

    multicycle_mips_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state !== 4'd0 || mem_read !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0 ||
                instr_count !== 32'd0 || illegal_op !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: state=%0d mem_read=%b ir_write=%b pc_write=%b cnt=%0d ill=%b, expected 0s",
                         state, mem_read, ir_write, pc_write, instr_count, illegal_op);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1 ||
            pc_source !== 2'd0 || alu_src_b !== 2'd1) begin
            bad++;
            $display("FAIL reset_release: state=%0d mem_read=%b ir_write=%b pc_write=%b pc_source=%0d alu_src_b=%0d, expected 0 1 1 1 0 1",
                     state, mem_read, ir_write, pc_write, pc_source, alu_src_b);
        end
        total++;
        if (instr_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d expected 0", instr_count);
        end
        exp_cnt = 32'd0;
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL fetch_stall: state=%0d ir_write=%b pc_write=%b mem_read=%b, expected 0 0 0 1",
                     state, ir_write, pc_write, mem_read);
        end
        step();
        total++;
        if (state !== 4'd0) begin
            bad++;
            $display("FAIL fetch_hold: state=%0d expected 0", state);
        end
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_lw();
        logic [3:0] seq [0:5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (state !== seq[i]) begin
                bad++;
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, seq[i]);
            end
            total++;
            if (reg_write !== (seq[i] == 4'd4) || mem_to_reg !== (seq[i] == 4'd4)) begin
                bad++;
                $display("FAIL lw_wb[%0d]: reg_write=%b mem_to_reg=%b expected %b", i, reg_write, mem_to_reg, seq[i] == 4'd4);
            end
            // Opcode changing after DECODE must not redirect the instruction.
            if (seq[i] == 4'd2) opcode = OP_SW;
            if (i < 5) step();
        end
        exp_cnt = exp_cnt + 32'd1;
        total++;
        if (instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL lw_count: got %0d expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_sw_stall();
        opcode = OP_SW; mem_ready = 1'b1;
        step();
        step();
        total++;
        if (state !== 4'd2) begin
            bad++;
            $display("FAIL sw_addr: state=%0d expected 2", state);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (state !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1 || instr_count !== exp_cnt) begin
                bad++;
                $display("FAIL sw_wait[%0d]: state=%0d mem_write=%b iord=%b cnt=%0d expected 5 1 1 %0d",
                         i, state, mem_write, iord, instr_count, exp_cnt);
            end
            if (i == 3) mem_ready = 1'b1;
        end
        step();
        exp_cnt = exp_cnt + 32'd1;
        total++;
        if (state !== 4'd0 || mem_write !== 1'b0 || instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL sw_done: state=%0d mem_write=%b cnt=%0d expected 0 0 %0d",
                     state, mem_write, instr_count, exp_cnt);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops    [0:3];
        logic       zs     [0:3];
        logic       exp_pw [0:3];
        ops    = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        zs     = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_pw = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; zero = zs[k]; mem_ready = 1'b1;
            step();
            step();
            total++;
            if (state !== 4'd8 || pc_write !== exp_pw[k] || pc_source !== 2'd1 ||
                alu_op !== 2'd1 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
                bad++;
                $display("FAIL branch[%0d]: state=%0d pc_write=%b pc_source=%0d alu_op=%0d srca=%b srcb=%0d expected 8 %b 1 1 1 0",
                         k, state, pc_write, pc_source, alu_op, alu_src_a, alu_src_b, exp_pw[k]);
            end
            step();
            exp_cnt = exp_cnt + 32'd1;
            total++;
            if (state !== 4'd0 || instr_count !== exp_cnt) begin
                bad++;
                $display("FAIL branch_done[%0d]: state=%0d cnt=%0d expected 0 %0d", k, state, instr_count, exp_cnt);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = OP_J; mem_ready = 1'b1;
        step();
        step();
        total++;
        if (state !== 4'd9 || pc_source !== 2'd2 || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL jump: state=%0d pc_source=%0d pc_write=%b expected 9 2 1", state, pc_source, pc_write);
        end
        step();
        exp_cnt = exp_cnt + 32'd1;
        total++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL jump_done: state=%0d cnt=%0d expected 0 %0d", state, instr_count, exp_cnt);
        end
    endtask

    task automatic test_rtype_addi();
        opcode = OP_R; mem_ready = 1'b1;
        step();
        step();
        total++;
        if (state !== 4'd6 || alu_op !== 2'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || reg_write !== 1'b0) begin
            bad++;
            $display("FAIL r_exec: state=%0d alu_op=%0d srca=%b srcb=%0d rw=%b expected 6 2 1 0 0",
                     state, alu_op, alu_src_a, alu_src_b, reg_write);
        end
        step();
        total++;
        if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            bad++;
            $display("FAIL r_wb: state=%0d rw=%b reg_dst=%b m2r=%b expected 7 1 1 0", state, reg_write, reg_dst, mem_to_reg);
        end
        opcode = OP_ADDI;
        step();
        exp_cnt = exp_cnt + 32'd1;
        total++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL r_done: state=%0d cnt=%0d expected 0 %0d", state, instr_count, exp_cnt);
        end
        step();
        step();
        total++;
        if (state !== 4'd10 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_op !== 2'd0) begin
            bad++;
            $display("FAIL addi_exec: state=%0d srca=%b srcb=%0d alu_op=%0d expected 10 1 2 0", state, alu_src_a, alu_src_b, alu_op);
        end
        step();
        total++;
        if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
            bad++;
            $display("FAIL addi_wb: state=%0d rw=%b reg_dst=%b expected 11 1 0", state, reg_write, reg_dst);
        end
        step();
        exp_cnt = exp_cnt + 32'd1;
        total++;
        if (state !== 4'd0 || instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL addi_done: state=%0d cnt=%0d expected 0 %0d", state, instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        step();
        total++;
        if (state !== 4'd1 || illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL ill_decode: state=%0d ill=%b expected 1 0", state, illegal_op);
        end
        step();
        total++;
        if (state !== 4'd0 || illegal_op !== 1'b1 || instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL ill_pulse: state=%0d ill=%b cnt=%0d expected 0 1 %0d", state, illegal_op, instr_count, exp_cnt);
        end
        mem_ready = 1'b0;
        step();
        total++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL ill_clear: state=%0d ill=%b expected 0 0", state, illegal_op);
        end
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid();
        opcode = OP_LW; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        total++;
        if (state !== 4'd3 || mem_read !== 1'b1 || iord !== 1'b1) begin
            bad++;
            $display("FAIL mid_memread: state=%0d mem_read=%b iord=%b expected 3 1 1", state, mem_read, iord);
        end
        reset = 1'b1;
        step();
        total++;
        if (state !== 4'd0 || mem_read !== 1'b0 || iord !== 1'b0 || ir_write !== 1'b0 ||
            pc_write !== 1'b0 || reg_write !== 1'b0 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: state=%0d mem_read=%b iord=%b ir_write=%b pc_write=%b rw=%b cnt=%0d expected 0s",
                     state, mem_read, iord, ir_write, pc_write, reg_write, instr_count);
        end
        reset = 1'b0; mem_ready = 1'b1;
        exp_cnt = 32'd0;
        #1;
    endtask

    task automatic test_wrap();
        force dut.instr_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_r;
        #1;
        total++;
        if (instr_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h expected ffffffff", instr_count);
        end
        opcode = OP_R; mem_ready = 1'b1;
        step();
        step();
        step();
        step();
        total++;
        if (state !== 4'd0 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL wrap: state=%0d cnt=%h expected 0 00000000", state, instr_count);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0; exp_cnt = 32'd0;
        test_reset();
        test_fetch_stall();
        test_lw();
        test_sw_stall();
        test_branch();
        test_jump();
        test_rtype_addi();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_mips_ctrl.md
Name: multicycle_mips_ctrl

Overview:
- Moore/Mealy control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath select and write enable.
- pc_source drives the PC-source 3-input mux select: 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target. Code 3 is never emitted.
- Also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
opcode  in  6  IR[31:26]; sampled in DECODE.
zero  in  1  ALU zero flag; used in BRANCH.
mem_ready  in  1  memory handshake: access completes in a cycle where mem_ready=1.
pc_write  out  1  PC load enable (branch condition already folded in).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  instruction register load.
reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
reg_write  out  1  register file write enable.
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
alu_op  out  2  ALU op class: 0 = add, 1 = sub, 2 = funct-decoded.
pc_source  out  2  PC-source 3-input mux select (0/1/2 only).
illegal_op  out  1  one-cycle pulse on an unsupported opcode.
instr_count  out  CNT_W  retired-instruction counter.
state  out  4  current state, for debug.

Behaviour:
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, BNE = 000101, J = 000010, ADDI = 001000.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- Reset (synchronous): state = FETCH, op_q = 0, instr_count = 0, illegal_op = 0.
  - While reset is high, all outputs are 0 except state (= 0) and instr_count (= 0).
  - Reset mid-instruction abandons the instruction without counting it.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read = 1, alu_src_b = 1, alu_op = 0, pc_source = 0.
  - ir_write = pc_write = mem_ready.
  - Holds in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - alu_src_b = 3, alu_op = 0; latches opcode into op_q.
  - Next state: LW/SW -> MEM_ADDR; R -> EXECUTE; BEQ/BNE -> BRANCH; J -> JUMP; ADDI -> ADDI_EXEC.
  - Any other opcode -> FETCH, with illegal_op = 1 in the following cycle only. Not counted.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2. Next: MEM_READ if op_q = LW, else MEM_WRITE.
- MEM_READ: mem_read = 1, iord = 1. Holds until mem_ready = 1, then MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
- MEM_WRITE: mem_write = 1, iord = 1. Holds until mem_ready = 1, then FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 0, alu_op = 2. Next: R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Next: FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_source = 1.
  - pc_write = (op_q == BEQ & zero) | (op_q == BNE & !zero).
  - Next: FETCH.
- JUMP: pc_source = 2, pc_write = 1. Next: FETCH.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 2. Next: ADDI_WB.
- ADDI_WB: reg_write = 1. Next: FETCH.
- Latency with mem_ready tied to 1: R 4, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI 4 cycles.
- instr_count:
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE (completed), R_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W.
- State codes 12-15: all outputs 0; next state FETCH; not counted.
- opcode changes outside DECODE are ignored; only op_q steers later states.
- mem_ready toggling in non-memory states has no effect.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encoding constants;
  - the opcode constants;
  - the alu_src_b, alu_op and pc_source code constants (PCSRC_ALU = 0, PCSRC_ALUOUT = 1, PCSRC_JUMP = 2).
- One sub-module, mips_ctrl_decode: combinational state + op_q + zero -> output vector. The FSM register, op_q and counter remain in the top level.

Test Plan:
- Reset held 3 cycles, then released with mem_ready = 1 -> state = 0; first cycle after release has mem_read = 1, ir_write = 1, pc_write = 1, pc_source = 0; instr_count = 0.
- LW (100011), mem_ready = 1 -> states 0, 1, 2, 3, 4, 0; reg_write = 1 and mem_to_reg = 1 only in state 4; instr_count = 1.
- SW with mem_ready held low 3 cycles in MEM_WRITE -> stays in state 5 for 4 cycles with mem_write = 1; returns to FETCH after mem_ready = 1; instr_count + 1.
- BEQ with zero = 1 -> pc_write = 1 and pc_source = 1 in state 8. BNE with zero = 1 -> pc_write = 0. J -> pc_source = 2 and pc_write = 1 in state 9.
- Opcode 111111 -> DECODE returns to FETCH; illegal_op pulses 1 cycle; instr_count unchanged.
- Reset asserted during MEM_READ -> next cycle state = 0, all enables 0, instr_count = 0. Separately, instr_count preloaded via force to 2^32-1 then an R-type retires -> instr_count = 0.
